// File: rtl/team_id_reader.sv
// MSP430 peripheral that debounces the radio-side team ID, commits it to a read-only
// TEAM_ID register, and reports change/tamper events through STATUS flags and a level IRQ.
module team_id_reader #(
  parameter logic [14:0] BASE_ADDR     = 15'h01C0,
  parameter int unsigned DEC_WD        = 3,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic [15:0] team_id_in,
  output logic [15:0] per_dout,
  output logic [15:0] team_id_out,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [DEC_WD-1:0] OFF_ID     = DEC_WD'(0);
  localparam logic [DEC_WD-1:0] OFF_CTRL   = DEC_WD'(2);
  localparam logic [DEC_WD-1:0] OFF_STATUS = DEC_WD'(4);
  localparam logic [DEC_WD-1:0] OFF_ACC    = DEC_WD'(6);

  typedef enum logic [1:0] {ST_SETTLE, ST_COMMIT, ST_SETTLED} state_t;

  state_t            state_q, state_d;
  logic [15:0]       cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       team_id_q, team_id_d;
  logic [15:0]       accept_cnt_q, accept_cnt_d;
  logic              ie_q, ie_d, lock_q, lock_d;
  logic              new_q, new_d, tamper_q, tamper_d;
  logic              commit_ok, commit_blk;
  logic              reg_sel, reg_wr, reg_rd, wr_ctrl, wr_status;
  logic [DEC_WD-1:0] reg_off;
  logic              unused_din;

  // Peripheral bus decode
  assign reg_sel   = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_off   = {per_addr[DEC_WD-2:0], 1'b0};
  assign reg_wr    = reg_sel & (|per_we);
  assign reg_rd    = reg_sel & ~(|per_we);
  assign wr_ctrl   = reg_wr & (reg_off == OFF_CTRL);
  assign wr_status = reg_wr & (reg_off == OFF_STATUS);
  assign unused_din = ^per_din[15:2];

  always_ff @(posedge mclk) begin
    if (puc_rst) state_q <= ST_SETTLED;
    else         state_q <= state_d;
  end

  // A differing input restarts filtering from any state, aborting a pending commit
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (team_id_in != cand_q) begin
      cand_d  = team_id_in;
      cnt_d   = CNT_W'(1);
      state_d = ST_SETTLE;
    end else begin
      unique case (state_q)
        ST_SETTLE: begin
          if (cnt_q == CNT_LAST) state_d = ST_COMMIT;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
        ST_COMMIT: state_d = ST_SETTLED;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    commit_ok  = 1'b0;
    commit_blk = 1'b0;
    if ((state_q == ST_COMMIT) && (team_id_in == cand_q) && (cand_q != team_id_q)) begin
      commit_ok  = ~lock_q;
      commit_blk = lock_q;
    end
  end

  // Hardware flag sets take priority over software W1C in the same cycle
  always_comb begin
    team_id_d    = commit_ok ? cand_q : team_id_q;
    ie_d         = wr_ctrl ? per_din[0] : ie_q;
    lock_d       = lock_q | (wr_ctrl & per_din[1]);
    new_d        = (new_q & ~(wr_status & per_din[0])) | commit_ok;
    tamper_d     = (tamper_q & ~(wr_status & per_din[1])) | commit_blk;
    accept_cnt_d = accept_cnt_q;
    if (commit_ok && (accept_cnt_q != 16'hFFFF)) accept_cnt_d = accept_cnt_q + 16'd1;
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      cand_q       <= '0;
      cnt_q        <= '0;
      team_id_q    <= '0;
      accept_cnt_q <= '0;
      ie_q         <= 1'b0;
      lock_q       <= 1'b0;
      new_q        <= 1'b0;
      tamper_q     <= 1'b0;
    end else begin
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      team_id_q    <= team_id_d;
      accept_cnt_q <= accept_cnt_d;
      ie_q         <= ie_d;
      lock_q       <= lock_d;
      new_q        <= new_d;
      tamper_q     <= tamper_d;
    end
  end

  always_comb begin
    per_dout = '0;
    if (reg_rd) begin
      case (reg_off)
        OFF_ID:     per_dout = team_id_q;
        OFF_CTRL:   per_dout = {14'd0, lock_q, ie_q};
        OFF_STATUS: per_dout = {13'd0, (state_q == ST_SETTLED), tamper_q, new_q};
        OFF_ACC:    per_dout = accept_cnt_q;
        default:    per_dout = '0;
      endcase
    end
  end

  assign team_id_out = team_id_q;
  assign irq         = ie_q & (new_q | tamper_q);

endmodule
